// File: rtl/shift_add_mul_if.sv
// Start/operand/result bundle between a requester and the shift_add_mul unit.
interface shift_add_mul_if #(
    parameter int unsigned N = 8
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mul.sv
// Multi-cycle unsigned shift-add multiplier: one N-bit add per cycle, 2N-bit product.
// Optional SHIFT_ADD_MUL_EARLY_TERM_EN exits RUN once the remaining multiplier bits are zero.
module shift_add_mul #(
    parameter int unsigned N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_add_mul_if.slave  mul
);
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned AW = 2 * N + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_mcand;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [2*N-1:0]  r_product;

    logic [N-1:0]    w_addend;
    logic [N:0]      w_sum;
    logic [AW-1:0]   w_step;
    logic [AW-1:0]   w_next;
    logic            w_last;
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    localparam logic [N-1:0] ONES = {N{1'b1}};
    logic [CW-1:0]   w_cnt_inc;
    logic [CW-1:0]   w_rem;
`endif

    // One shift-add step; the carry bit of acc is always 0, so folding it into the
    // upper operand keeps the add exact while giving it a reader.
    always_comb begin
        w_addend = r_acc[0] ? r_mcand : '0;
        w_sum    = r_acc[AW-1:N] + {1'b0, w_addend};
        w_step   = {1'b0, w_sum, r_acc[N-1:1]};
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        w_cnt_inc = r_cnt + CW'(1);
        w_rem     = LAST - r_cnt;
        w_last    = ((w_step[N-1:0] & (ONES >> w_cnt_inc)) == '0);
        w_next    = w_last ? (w_step >> w_rem) : w_step;
`else
        w_last    = (r_cnt == LAST);
        w_next    = w_step;
`endif
    end

    // DONE doubles as an accept slot so a held start re-triggers every N+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (mul.start) begin
                        r_mcand <= mul.a;
                        r_acc   <= {{(N + 1){1'b0}}, mul.b};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= w_next[2*N-1:0];
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul.busy    = r_busy;
    assign mul.done    = r_done;
    assign mul.product = r_product;
endmodule
